// File: rtl/accel_pkg.sv
// Shared LIS3DH register map, SPI command bits, FSM/phase enums and sample type
// for the accelerometer poller and its SPI transaction controller.
package accel_pkg;

   localparam logic [7:0] REG_CTRL1   = 8'h20;
   localparam logic [7:0] REG_WHOAMI  = 8'h0F;
   localparam logic [7:0] REG_OUT_X_L = 8'h28;
   localparam logic [7:0] REG_OUT_X_H = 8'h29;
   localparam logic [7:0] REG_OUT_Y_L = 8'h2A;
   localparam logic [7:0] REG_OUT_Y_H = 8'h2B;
   localparam logic [7:0] REG_OUT_Z_L = 8'h2C;
   localparam logic [7:0] REG_OUT_Z_H = 8'h2D;

   localparam logic [7:0] SPI_RD_BIT = 8'h80;
   localparam logic [7:0] SPI_AI_BIT = 8'h40;

   localparam logic [5:0] NBITS_REG = 6'd16;
   localparam logic [5:0] NBITS_XYZ = 6'd24;

   localparam int INIT_CYCLES = 1024;

   typedef enum logic [3:0] {
      INIT_WAIT,
      WR_CTRL,
      RD_ID,
      IDLE,
      RD_X,
      RD_Y,
      RD_Z,
      PUBLISH,
      ERROR
   } poll_state_e;

   typedef enum logic [1:0] {
      T_IDLE,
      T_WAIT_LO,
      T_WAIT_HI
   } txn_phase_e;

   typedef logic signed [15:0] axis_t;

   function automatic logic [7:0] rd_cmd(input logic [7:0] addr,
                                         input logic       ai);
      rd_cmd = addr | SPI_RD_BIT | (ai ? SPI_AI_BIT : 8'h00);
   endfunction

endpackage

// File: rtl/spi_txn_ctrl.sv
// One request/ready handshake with spi_master: issue, wait busy, wait idle, capture.
// Ports: start_i/mosi_i/nbits_i from FSM; spi_* to spi_master; done_o/rdata_o/timeout_o back.
module spi_txn_ctrl
   import accel_pkg::*;
#(
   parameter int TIMEOUT = 4096
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] mosi_i,
   input  logic [5:0]  nbits_i,
   input  logic        spi_ready_i,
   input  logic [15:0] spi_miso_i,
   output logic [31:0] spi_mosi_o,
   output logic [5:0]  spi_nbits_o,
   output logic        spi_request_o,
   output logic        done_o,
   output logic [15:0] rdata_o,
   output logic        timeout_o
);

   localparam int TW = $clog2(TIMEOUT + 1);

   txn_phase_e    ph_q, ph_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [31:0]   mosi_q, mosi_d;
   logic [5:0]    nbits_q, nbits_d;
   logic          req_q, req_d;

   assign spi_mosi_o    = mosi_q;
   assign spi_nbits_o   = nbits_q;
   assign spi_request_o = req_q;
   assign rdata_o       = spi_miso_i;

   always_comb begin
      ph_d      = ph_q;
      tmr_d     = tmr_q;
      mosi_d    = mosi_q;
      nbits_d   = nbits_q;
      req_d     = 1'b0;
      done_o    = 1'b0;
      timeout_o = 1'b0;
      unique case (ph_q)
         T_IDLE: begin
            if (start_i && spi_ready_i) begin
               mosi_d  = mosi_i;
               nbits_d = nbits_i;
               req_d   = 1'b1;
               tmr_d   = '0;
               ph_d    = T_WAIT_LO;
            end
         end
         T_WAIT_LO: begin
            if (!spi_ready_i) ph_d = T_WAIT_HI;
         end
         T_WAIT_HI: begin
            if (spi_ready_i) begin
               done_o = 1'b1;
               ph_d   = T_IDLE;
            end
         end
         default: ph_d = T_IDLE;
      endcase
      // timer counts edges since the request edge; the last allowed
      // edge is TIMEOUT after it
      if (ph_q != T_IDLE && !done_o) begin
         if (tmr_q == TW'(TIMEOUT - 1)) begin
            timeout_o = 1'b1;
            ph_d      = T_IDLE;
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ph_q    <= T_IDLE;
         tmr_q   <= '0;
         mosi_q  <= '0;
         nbits_q <= '0;
         req_q   <= 1'b0;
      end else begin
         ph_q    <= ph_d;
         tmr_q   <= tmr_d;
         mosi_q  <= mosi_d;
         nbits_q <= nbits_d;
         req_q   <= req_d;
      end
   end

endmodule

// File: rtl/accel_xyz_poller.sv
// LIS3DH sequencer: configure, check WHO_AM_I, poll X/Y/Z at a fixed rate.
// Ports: clk_in/rst; spi_* to spi_master; sample_*/sample_valid, id_ok, error out.
module accel_xyz_poller
   import accel_pkg::*;
#(
   parameter int         POLL_DIV   = 120000,
   parameter logic [7:0] CTRL1_VAL  = 8'h77,
   parameter logic [7:0] WHOAMI_VAL = 8'h33,
   parameter int         TIMEOUT    = 4096
) (
   input  logic        clk_in,
   input  logic        rst,
   output logic [31:0] spi_mosi_data,
   input  logic [31:0] spi_miso_data,
   output logic [5:0]  spi_nbits,
   output logic        spi_request,
   input  logic        spi_ready,
   output logic [15:0] sample_x,
   output logic [15:0] sample_y,
   output logic [15:0] sample_z,
   output logic        sample_valid,
   output logic        id_ok,
   output logic        error
);

   poll_state_e state_q, state_d;
   logic [9:0]  wait_q, wait_d;
   logic [23:0] poll_q, poll_d;
   logic        pend_q, pend_d;
   axis_t       x_q, x_d, y_q, y_d, z_q, z_d;
   axis_t       sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
   logic        valid_q, valid_d;
   logic        idok_q, idok_d;

   logic        tick;
   logic        start;
   logic [31:0] cmd_word;
   logic [5:0]  cmd_nbits;
   logic        done;
   logic [15:0] rdata;
   logic        tmo;

   // received bits above the longest transaction are don't-care
   logic        miso_unused;
   assign miso_unused = ^spi_miso_data[31:16];

   spi_txn_ctrl #(
      .TIMEOUT(TIMEOUT)
   ) u_txn (
      .clk_i        (clk_in),
      .rst_i        (rst),
      .start_i      (start),
      .mosi_i       (cmd_word),
      .nbits_i      (cmd_nbits),
      .spi_ready_i  (spi_ready),
      .spi_miso_i   (spi_miso_data[15:0]),
      .spi_mosi_o   (spi_mosi_data),
      .spi_nbits_o  (spi_nbits),
      .spi_request_o(spi_request),
      .done_o       (done),
      .rdata_o      (rdata),
      .timeout_o    (tmo)
   );

   assign tick         = idok_q && (poll_q == 24'(POLL_DIV - 1));
   assign sample_x     = sx_q;
   assign sample_y     = sy_q;
   assign sample_z     = sz_q;
   assign sample_valid = valid_q;
   assign id_ok        = idok_q;
   assign error        = (state_q == ERROR);

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      pend_d    = pend_q;
      x_d       = x_q;
      y_d       = y_q;
      z_d       = z_q;
      sx_d      = sx_q;
      sy_d      = sy_q;
      sz_d      = sz_q;
      valid_d   = 1'b0;
      idok_d    = idok_q;
      start     = 1'b0;
      cmd_word  = '0;
      cmd_nbits = NBITS_REG;
      poll_d    = '0;
      if (idok_q) poll_d = tick ? '0 : poll_q + 1'b1;
      // one pending slot: extra ticks during a busy poll are dropped
      if (tick && state_q != IDLE) pend_d = 1'b1;
      unique case (state_q)
         INIT_WAIT: begin
            if (wait_q == 10'(INIT_CYCLES - 1)) state_d = WR_CTRL;
            else wait_d = wait_q + 1'b1;
         end
         WR_CTRL: begin
            start    = 1'b1;
            cmd_word = {16'h0, REG_CTRL1, CTRL1_VAL};
            if (done) state_d = RD_ID;
         end
         RD_ID: begin
            start    = 1'b1;
            cmd_word = {16'h0, rd_cmd(REG_WHOAMI, 1'b0), 8'h00};
            if (done) begin
               if (rdata[7:0] == WHOAMI_VAL) begin
                  idok_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = ERROR;
               end
            end
         end
         IDLE: begin
            if (tick || pend_q) begin
               pend_d  = 1'b0;
               state_d = RD_X;
            end
         end
         // first data byte is the L register, second the H register
         RD_X: begin
            start     = 1'b1;
            cmd_nbits = NBITS_XYZ;
            cmd_word  = {8'h0, rd_cmd(REG_OUT_X_L, 1'b1), 16'h0};
            if (done) begin
               x_d     = {rdata[7:0], rdata[15:8]};
               state_d = RD_Y;
            end
         end
         RD_Y: begin
            start     = 1'b1;
            cmd_nbits = NBITS_XYZ;
            cmd_word  = {8'h0, rd_cmd(REG_OUT_Y_L, 1'b1), 16'h0};
            if (done) begin
               y_d     = {rdata[7:0], rdata[15:8]};
               state_d = RD_Z;
            end
         end
         RD_Z: begin
            start     = 1'b1;
            cmd_nbits = NBITS_XYZ;
            cmd_word  = {8'h0, rd_cmd(REG_OUT_Z_L, 1'b1), 16'h0};
            if (done) begin
               z_d     = {rdata[7:0], rdata[15:8]};
               state_d = PUBLISH;
            end
         end
         PUBLISH: begin
            sx_d    = x_q;
            sy_d    = y_q;
            sz_d    = z_q;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         ERROR: state_d = ERROR;
         default: state_d = ERROR;
      endcase
      if (tmo) state_d = ERROR;
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= INIT_WAIT;
         wait_q  <= '0;
         poll_q  <= '0;
         pend_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         sz_q    <= '0;
         valid_q <= 1'b0;
         idok_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         poll_q  <= poll_d;
         pend_q  <= pend_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         sz_q    <= sz_d;
         valid_q <= valid_d;
         idok_q  <= idok_d;
      end
   end

endmodule

// File: tb/tb_accel_xyz_poller.sv
// Bench for accel_xyz_poller: spi_master + LIS3DH behavioural model,
// sample scoreboard, timeout stub, stretched transactions, mid-poll reset.
module tb_accel_xyz_poller;

   localparam int POLL = 200;
   localparam int TMO  = 300;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
   } vec_t;

   logic        clk_in = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] spi_mosi_data;
   logic [31:0] spi_miso_data;
   logic [5:0]  spi_nbits;
   logic        spi_request;
   logic        spi_ready;
   logic [15:0] sample_x, sample_y, sample_z;
   logic        sample_valid, id_ok, error;

   vec_t        vecs[4];
   vec_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [7:0]  whoami = 8'h33;
   int          busy_len = 4;
   bit          never_busy = 0;
   bit          force_low = 1;
   int          txn_k = 0;
   int          req_count = 0;
   int          z_count = 0;
   int          valid_count = 0;
   int          vidx = 0;
   bit          seen_ea = 0;

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   accel_xyz_poller #(
      .POLL_DIV  (POLL),
      .CTRL1_VAL (8'h77),
      .WHOAMI_VAL(8'h33),
      .TIMEOUT   (TMO)
   ) dut (
      .clk_in       (clk_in),
      .rst          (rst),
      .spi_mosi_data(spi_mosi_data),
      .spi_miso_data(spi_miso_data),
      .spi_nbits    (spi_nbits),
      .spi_request  (spi_request),
      .spi_ready    (spi_ready),
      .sample_x     (sample_x),
      .sample_y     (sample_y),
      .sample_z     (sample_z),
      .sample_valid (sample_valid),
      .id_ok        (id_ok),
      .error        (error)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input int k);
      if (k == 0) return 32'h0000_2077;
      if (k == 1) return 32'h0000_8F00;
      case ((k - 2) % 3)
         0: return 32'h00E8_0000;
         1: return 32'h00EA_0000;
         default: return 32'h00EC_0000;
      endcase
   endfunction

   function automatic logic [31:0] exp_nbits(input int k);
      return (k < 2) ? 32'd16 : 32'd24;
   endfunction

   // spi_master + LIS3DH model
   initial begin
      logic [31:0] mw;
      logic [5:0]  nb;
      logic [7:0]  cmd;
      logic [31:0] miso;
      bit          busy;
      int          bc;
      busy = 0;
      bc = 0;
      mw = '0;
      nb = '0;
      spi_ready = 1'b0;
      spi_miso_data = '0;
      forever begin
         @(posedge clk_in);
         #1;
         if (rst) begin
            busy = 0;
            spi_ready = !force_low;
            txn_k = 0;
            vidx = 0;
            sb_q.delete();
         end else if (force_low) begin
            spi_ready = 1'b0;
            if (spi_request) req_count++;
         end else if (!busy) begin
            spi_ready = 1'b1;
            if (spi_request) begin
               mw = spi_mosi_data;
               nb = spi_nbits;
               req_count++;
               chk($sformatf("txn%0d_mosi", txn_k), mw, exp_word(txn_k));
               chk($sformatf("txn%0d_nbits", txn_k), 32'(nb), exp_nbits(txn_k));
               txn_k++;
               if (nb == 6'd24 && mw[23:16] == 8'hEA) seen_ea = 1;
               if (!never_busy) begin
                  busy = 1;
                  bc = busy_len;
                  spi_ready = 1'b0;
               end
            end
         end else begin
            if (spi_request) begin
               checks++;
               errors++;
               $display("FAIL req_while_busy actual=1 required=0");
            end
            bc--;
            if (bc == 0) begin
               chk("mosi_stable", spi_mosi_data, mw);
               cmd = (nb == 6'd24) ? mw[23:16] : mw[15:8];
               miso = $urandom;
               if (cmd[7]) begin
                  case (cmd[5:0])
                     6'h0F: miso[7:0] = whoami;
                     6'h28: miso[15:0] = {vecs[vidx].x[7:0], vecs[vidx].x[15:8]};
                     6'h2A: miso[15:0] = {vecs[vidx].y[7:0], vecs[vidx].y[15:8]};
                     6'h2C: begin
                        miso[15:0] = {vecs[vidx].z[7:0], vecs[vidx].z[15:8]};
                        sb_q.push_back(vecs[vidx]);
                        z_count++;
                        vidx = (vidx + 1) % 4;
                     end
                     default: ;
                  endcase
               end
               spi_miso_data = miso;
               spi_ready = 1'b1;
               busy = 0;
            end
         end
      end
   end

   // samples may only move together with sample_valid
   initial begin
      logic [47:0] prev;
      bit          prst;
      prev = '0;
      prst = 1;
      forever begin
         @(negedge clk_in);
         if (!rst && !prst && !sample_valid &&
             {sample_x, sample_y, sample_z} !== prev) begin
            checks++;
            errors++;
            $display("FAIL tearing actual=%h required=%h",
                     {sample_x, sample_y, sample_z}, prev);
         end
         if (sample_valid && !rst) valid_count++;
         prev = {sample_x, sample_y, sample_z};
         prst = rst;
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_mosi"}, spi_mosi_data, 32'h0);
      chk({tag, "_nbits"}, 32'(spi_nbits), 32'h0);
      chk({tag, "_req"}, 32'(spi_request), 32'h0);
      chk({tag, "_samples"}, 32'(|{sample_x, sample_y, sample_z}), 32'h0);
      chk({tag, "_valid"}, 32'(sample_valid), 32'h0);
      chk({tag, "_idok"}, 32'(id_ok), 32'h0);
      chk({tag, "_error"}, 32'(error), 32'h0);
   endtask

   task automatic do_reset(input logic [7:0] who, input int bl,
                           input bit nbz, input bit fl);
      rst = 1'b1;
      whoami = who;
      busy_len = bl;
      never_busy = nbz;
      force_low = fl;
      seen_ea = 0;
      repeat (3) @(negedge clk_in);
      req_count = 0;
      z_count = 0;
      valid_count = 0;
      rst = 1'b0;
   endtask

   task automatic wait_idok(input int budget);
      int n;
      n = 0;
      while (id_ok !== 1'b1 && n < budget) begin
         @(negedge clk_in);
         n++;
      end
      chk("id_ok_up", 32'(id_ok), 32'h1);
   endtask

   task automatic get_sample(input int budget, input string tag, output int at);
      int   n;
      vec_t e;
      n = 0;
      at = -1;
      while (sample_valid !== 1'b1 && n < budget) begin
         @(negedge clk_in);
         n++;
      end
      if (sample_valid !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s_wait actual=no_sample required=sample_valid", tag);
      end else begin
         at = cyc;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb actual=empty required=entry", tag);
         end else begin
            e = sb_q.pop_front();
            chk({tag, "_x"}, 32'(sample_x), 32'(e.x));
            chk({tag, "_y"}, 32'(sample_y), 32'(e.y));
            chk({tag, "_z"}, 32'(sample_z), 32'(e.z));
         end
         @(negedge clk_in);
      end
   endtask

   initial begin
      int n;
      int at;
      int prev_at;
      int c0;
      vecs[0] = '{16'h1234, 16'hFF00, 16'h8001};
      vecs[1] = '{16'h7FFF, 16'h8000, 16'h0000};
      vecs[2] = '{16'hFFFF, 16'h0001, 16'h00FF};
      vecs[3] = '{16'h5AA5, 16'hA55A, 16'h0100};

      // 1: reset state, ready held low, then config + ID
      repeat (2) @(negedge clk_in);
      chk_zero("reset");
      do_reset(8'h33, 4, 0, 1);
      repeat (1200) @(negedge clk_in);
      chk("hold_no_req", req_count, 0);
      force_low = 0;
      wait_idok(200);
      chk("init_error", 32'(error), 32'h0);
      chk("init_reqs", req_count, 2);

      // 2: ID mismatch
      do_reset(8'h32, 4, 0, 0);
      n = 0;
      while (error !== 1'b1 && n < 1500) begin
         @(negedge clk_in);
         n++;
      end
      chk("badid_error", 32'(error), 32'h1);
      chk("badid_idok", 32'(id_ok), 32'h0);
      repeat (3 * POLL) @(negedge clk_in);
      chk("badid_reqs", req_count, 2);

      // 3: polling at the full rate
      do_reset(8'h33, 4, 0, 0);
      wait_idok(1500);
      prev_at = 0;
      for (int i = 0; i < 4; i++) begin
         get_sample(POLL + 200, $sformatf("poll%0d", i), at);
         if (i == 0) chk("y_neg256", 32'($signed(sample_y)), 32'hFFFF_FF00);
         if (i > 0) chk("valid_period", at - prev_at, POLL);
         prev_at = at;
      end

      // 4: never-busy stub -> timeout
      do_reset(8'h33, 4, 1, 0);
      n = 0;
      while (spi_request !== 1'b1 && n < 1500) begin
         @(negedge clk_in);
         n++;
      end
      chk("tmo_req_seen", 32'(spi_request), 32'h1);
      n = 0;
      while (error !== 1'b1 && n < TMO + 50) begin
         @(negedge clk_in);
         n++;
      end
      chk("tmo_cycles", n, TMO);
      repeat (100) @(negedge clk_in);
      chk("tmo_reqs", req_count, 1);

      // 5: stretched transactions, ticks overrun
      do_reset(8'h33, 150, 0, 0);
      wait_idok(2000);
      prev_at = 0;
      for (int i = 0; i < 4; i++) begin
         get_sample(1200, $sformatf("slow%0d", i), at);
         if (i > 0) chk("slow_gap_ge450", 32'((at - prev_at) >= 450), 32'h1);
         chk("slow_sb_drained", sb_q.size(), 0);
         prev_at = at;
      end
      chk("slow_valid_vs_polls", valid_count, z_count);
      chk("slow_error", 32'(error), 32'h0);

      // 6: reset during RD_Y
      do_reset(8'h33, 4, 0, 0);
      wait_idok(1500);
      get_sample(POLL + 200, "pre_rst", at);
      seen_ea = 0;
      n = 0;
      while (!seen_ea && n < 400) begin
         @(negedge clk_in);
         n++;
      end
      chk("rdy_seen", 32'(seen_ea), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      repeat (3) @(negedge clk_in);
      req_count = 0;
      rst = 1'b0;
      c0 = cyc;
      n = 0;
      while (req_count < 1 && n < 1500) begin
         @(negedge clk_in);
         n++;
      end
      chk("reinit_req", req_count, 1);
      chk("reinit_delay_ge1024", 32'((cyc - c0) >= 1024), 32'h1);
      wait_idok(400);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
